// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue
// Buffered, handshaked RV32I decode stage sitting between fetch and dispatch.
// Fetched instructions (with their PC) are written into a DEPTH-entry FIFO.
// The head entry is decoded combinationally and offered to the dispatcher over
// a valid/ready interface. A flush discards every queued entry.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   flush        : drop all queued entries (mispredict / exception)
//   if_valid     : fetch offers if_instr / if_pc
//   if_ready     : queue has room this cycle (from registered count only)
//   if_instr     : raw RV32I instruction
//   if_pc        : PC of if_instr
//   dq_valid     : decoded head entry present
//   dq_ready     : dispatcher takes the head this cycle
//   dq_pc        : PC of head
//   dq_opcode .. dq_func7 : raw instruction fields of head
//   dq_rd_en, dq_rs1_en, dq_rs2_en : register write / read enables of head
//   dq_imm       : sign-extended immediate for the head's format
//   dq_illegal   : head opcode is outside the supported set
//   dq_count     : current occupancy
// All dq_* outputs are forced to zero while the queue is empty.
// -----------------------------------------------------------------------------
module decode_queue #(
    parameter  int DEPTH = 4,
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             dq_valid,
    input  logic             dq_ready,
    output logic [XLEN-1:0]  dq_pc,
    output logic [6:0]       dq_opcode,
    output logic [4:0]       dq_rd,
    output logic [2:0]       dq_func3,
    output logic [4:0]       dq_rs1,
    output logic [4:0]       dq_rs2,
    output logic [6:0]       dq_func7,
    output logic             dq_rd_en,
    output logic             dq_rs1_en,
    output logic             dq_rs2_en,
    output logic [XLEN-1:0]  dq_imm,
    output logic             dq_illegal,
    output logic [CNT_W-1:0] dq_count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Storage (data only; no reset needed because outputs are gated by count)
    logic [XLEN-1:0]  r_instr [DEPTH];
    logic [XLEN-1:0]  r_pc    [DEPTH];

    // Control state
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic [XLEN-1:0]  w_instr;
    logic [XLEN-1:0]  w_pc;
    logic [6:0]       w_opcode;
    logic             w_writes_rd;
    logic             w_rs1_en;
    logic             w_rs2_en;
    logic             w_illegal;
    logic [XLEN-1:0]  w_imm;

    assign w_valid  = (r_count != '0);
    assign if_ready = (r_count < CNT_W'(DEPTH));
    assign w_push   = if_valid && if_ready;
    assign w_pop    = w_valid && dq_ready;

    // Pointer / occupancy update. Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by natural overflow
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry write; a push coinciding with flush or reset is dropped
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_instr[r_wr_ptr] <= if_instr;
            r_pc[r_wr_ptr]    <= if_pc;
        end
    end

    // Head entry, zeroed when empty so no stale data leaks onto dq_*
    assign w_instr  = w_valid ? r_instr[r_rd_ptr] : '0;
    assign w_pc     = w_valid ? r_pc[r_rd_ptr]    : '0;
    assign w_opcode = w_instr[6:0];

    always_comb begin
        w_writes_rd = 1'b0;
        w_rs1_en    = 1'b0;
        w_rs2_en    = 1'b0;
        w_illegal   = 1'b0;
        w_imm       = '0;
        case (w_opcode)
            OP_R: begin
                w_writes_rd = 1'b1;
                w_rs1_en    = 1'b1;
                w_rs2_en    = 1'b1;
            end
            OP_I, OP_LOAD, OP_JALR: begin
                w_writes_rd = 1'b1;
                w_rs1_en    = 1'b1;
                w_imm       = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
            end
            OP_STORE: begin
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_imm    = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            OP_BRANCH: begin
                w_rs1_en = 1'b1;
                w_rs2_en = 1'b1;
                w_imm    = {{(XLEN-13){w_instr[31]}}, w_instr[31], w_instr[7],
                            w_instr[30:25], w_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                w_writes_rd = 1'b1;
                w_imm       = {{(XLEN-21){w_instr[31]}}, w_instr[31], w_instr[19:12],
                               w_instr[20], w_instr[30:21], 1'b0};
            end
            OP_AUIPC, OP_LUI: begin
                w_writes_rd = 1'b1;
                w_imm       = {{(XLEN-32){w_instr[31]}}, w_instr[31:12], 12'b0};
            end
            default: begin
                // An empty queue presents opcode 0; only flag real entries
                w_illegal = w_valid;
            end
        endcase
    end

    assign dq_valid   = w_valid;
    assign dq_pc      = w_pc;
    assign dq_opcode  = w_opcode;
    assign dq_rd      = w_instr[11:7];
    assign dq_func3   = w_instr[14:12];
    assign dq_rs1     = w_instr[19:15];
    assign dq_rs2     = w_instr[24:20];
    assign dq_func7   = w_instr[31:25];
    assign dq_rd_en   = w_writes_rd && (w_instr[11:7] != 5'd0);
    assign dq_rs1_en  = w_rs1_en;
    assign dq_rs2_en  = w_rs2_en;
    assign dq_imm     = w_imm;
    assign dq_illegal = w_illegal;
    assign dq_count   = r_count;

endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             if_valid;
    logic             if_ready;
    logic [XLEN-1:0]  if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             dq_valid;
    logic             dq_ready;
    logic [XLEN-1:0]  dq_pc;
    logic [6:0]       dq_opcode;
    logic [4:0]       dq_rd;
    logic [2:0]       dq_func3;
    logic [4:0]       dq_rs1;
    logic [4:0]       dq_rs2;
    logic [6:0]       dq_func7;
    logic             dq_rd_en;
    logic             dq_rs1_en;
    logic             dq_rs2_en;
    logic [XLEN-1:0]  dq_imm;
    logic             dq_illegal;
    logic [CNT_W-1:0] dq_count;

    decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .dq_valid(dq_valid), .dq_ready(dq_ready), .dq_pc(dq_pc),
        .dq_opcode(dq_opcode), .dq_rd(dq_rd), .dq_func3(dq_func3),
        .dq_rs1(dq_rs1), .dq_rs2(dq_rs2), .dq_func7(dq_func7),
        .dq_rd_en(dq_rd_en), .dq_rs1_en(dq_rs1_en), .dq_rs2_en(dq_rs2_en),
        .dq_imm(dq_imm), .dq_illegal(dq_illegal), .dq_count(dq_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode, written from the instruction-set rules
    function automatic void ref_dec(input logic [31:0] ins, output logic wr,
                                    output logic r1, output logic r2,
                                    output logic ill, output logic [31:0] imm);
        logic [6:0] op;
        op  = ins[6:0];
        wr  = (op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h6F, 7'h17, 7'h37}) && (ins[11:7] != 5'd0);
        r1  = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        r2  = op inside {7'h33, 7'h23, 7'h63};
        ill = !(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37});
        case (op)
            7'h13, 7'h03, 7'h67: imm = 32'(signed'(ins[31:20]));
            7'h23:               imm = 32'(signed'({ins[31:25], ins[11:7]}));
            7'h63:               imm = 32'(signed'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'h17, 7'h37:        imm = ins & 32'hFFFF_F000;
            7'h6F:               imm = 32'(signed'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default:             imm = 32'd0;
        endcase
    endfunction

    // Behavioural model: a queue of {pc, instr}
    logic [63:0] mq[$];
    logic        m_push;
    logic        m_pop;

    always @(posedge clk) begin
        m_push = if_valid && (mq.size() < DEPTH);
        m_pop  = (mq.size() != 0) && dq_ready;
        if (rst || flush) begin
            mq.delete();
            m_push = 1'b0;
        end else begin
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({if_pc, if_instr});
        end
    end

    // Every-cycle compare against the model
    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] ins, pc, e_imm;
            logic e_wr, e_r1, e_r2, e_ill, nonempty;
            nonempty = (mq.size() != 0);
            ins = nonempty ? mq[0][31:0]  : 32'd0;
            pc  = nonempty ? mq[0][63:32] : 32'd0;
            ref_dec(ins, e_wr, e_r1, e_r2, e_ill, e_imm);
            if (!nonempty) begin
                e_wr = 0; e_r1 = 0; e_r2 = 0; e_ill = 0; e_imm = 0;
            end
            chk("m_valid",   32'(dq_valid),   32'(nonempty));
            chk("m_if_ready",32'(if_ready),   32'(mq.size() < DEPTH));
            chk("m_count",   32'(dq_count),   32'(mq.size()));
            chk("m_pc",      dq_pc,           pc);
            chk("m_opcode",  32'(dq_opcode),  32'(ins[6:0]));
            chk("m_rd",      32'(dq_rd),      32'(ins[11:7]));
            chk("m_func3",   32'(dq_func3),   32'(ins[14:12]));
            chk("m_rs1",     32'(dq_rs1),     32'(ins[19:15]));
            chk("m_rs2",     32'(dq_rs2),     32'(ins[24:20]));
            chk("m_func7",   32'(dq_func7),   32'(ins[31:25]));
            chk("m_rd_en",   32'(dq_rd_en),   32'(e_wr));
            chk("m_rs1_en",  32'(dq_rs1_en),  32'(e_r1));
            chk("m_rs2_en",  32'(dq_rs2_en),  32'(e_r2));
            chk("m_imm",     dq_imm,          e_imm);
            chk("m_illegal", 32'(dq_illegal), 32'(e_ill));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        dq_ready = 1'b0;
        step();
        if_valid = 1'b0;
    endtask

    task automatic pop_one();
        dq_ready = 1'b1;
        step();
        dq_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   k;
        logic [31:0] r;
        logic [31:0] pc_ctr;
        logic [6:0]  ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37, 7'h7F};

        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; dq_ready = 1'b0;
        if_instr = '0; if_pc = '0;
        step();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_valid",    32'(dq_valid), 32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd1);
        chk("rst_count",    32'(dq_count), 32'd0);
        chk("rst_pc",       dq_pc,         32'd0);
        step();
        rst = 1'b0;

        // add x3,x1,x2
        push_one(32'h002081B3, 32'h100);
        @(negedge clk);
        chk("add_valid", 32'(dq_valid), 32'd1);
        chk("add_rd",    32'(dq_rd),    32'd3);
        chk("add_rs1",   32'(dq_rs1),   32'd1);
        chk("add_rs2",   32'(dq_rs2),   32'd2);
        chk("add_en",    {29'd0, dq_rd_en, dq_rs1_en, dq_rs2_en}, 32'd7);
        chk("add_imm",   dq_imm,        32'd0);
        pop_one();

        // sw x2,8(x1) then lw x4,0(x1)
        push_one(32'h0020A423, 32'h104);
        push_one(32'h0000A203, 32'h108);
        @(negedge clk);
        chk("sw_en",  {29'd0, dq_rd_en, dq_rs1_en, dq_rs2_en}, 32'd3);
        chk("sw_imm", dq_imm, 32'd8);
        pop_one();
        @(negedge clk);
        chk("lw_rd",  32'(dq_rd), 32'd4);
        chk("lw_en",  {29'd0, dq_rd_en, dq_rs1_en, dq_rs2_en}, 32'd6);
        chk("lw_pc",  dq_pc, 32'h108);
        pop_one();

        // addi x0,x0,0 then an unsupported opcode
        push_one(32'h00000013, 32'h10C);
        push_one(32'h0000007F, 32'h110);
        @(negedge clk);
        chk("nop_en",  {29'd0, dq_rd_en, dq_rs1_en, dq_rs2_en}, 32'd2);
        chk("nop_ill", 32'(dq_illegal), 32'd0);
        pop_one();
        @(negedge clk);
        chk("ill_flag", 32'(dq_illegal), 32'd1);
        chk("ill_en",   {29'd0, dq_rd_en, dq_rs1_en, dq_rs2_en}, 32'd0);
        pop_one();

        // Fill past capacity with if_valid held high
        dq_ready = 1'b0;
        k = 0;
        repeat (6) begin
            if_valid = 1'b1;
            if_instr = 32'h00000013 | (32'(k + 1) << 7);
            if_pc    = 32'h200 + 32'(4 * k);
            @(negedge clk);
            acc = if_ready;
            step();
            if (acc) k++;
        end
        @(negedge clk);
        chk("full_count",    32'(dq_count), 32'd4);
        chk("full_if_ready", 32'(if_ready), 32'd0);
        dq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("order_pc", dq_pc, 32'h200 + 32'(4 * i));
            acc = if_ready;
            step();
            if (acc) if_valid = 1'b0;
            @(negedge clk);
        end
        chk("fifth_pc",    dq_pc, 32'h210);
        chk("fifth_count", 32'(dq_count), 32'd1);
        step();
        dq_ready = 1'b0;

        // Simultaneous push and pop at count 2
        push_one(32'h00108093, 32'h300);
        push_one(32'h00210113, 32'h304);
        if_valid = 1'b1; if_instr = 32'h00318193; if_pc = 32'h308; dq_ready = 1'b1;
        step();
        if_valid = 1'b0; dq_ready = 1'b0;
        @(negedge clk);
        chk("pp_count", 32'(dq_count), 32'd2);
        chk("pp_pc",    dq_pc, 32'h304);
        dq_ready = 1'b1;
        step(); step();
        dq_ready = 1'b0;

        // Flush at count 3 with a same-cycle push
        push_one(32'h00108093, 32'h400);
        push_one(32'h00108093, 32'h404);
        push_one(32'h00108093, 32'h408);
        flush = 1'b1; if_valid = 1'b1; if_pc = 32'h40C;
        step();
        flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        chk("fl_count",    32'(dq_count), 32'd0);
        chk("fl_valid",    32'(dq_valid), 32'd0);
        chk("fl_if_ready", 32'(if_ready), 32'd1);

        // Reset mid-stream
        push_one(32'h0020A423, 32'h500);
        push_one(32'h0020A423, 32'h504);
        rst = 1'b1; if_valid = 1'b1;
        step();
        rst = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        chk("mr_count",    32'(dq_count), 32'd0);
        chk("mr_valid",    32'(dq_valid), 32'd0);
        chk("mr_if_ready", 32'(if_ready), 32'd1);
        chk("mr_imm",      dq_imm, 32'd0);

        // Randomized traffic; stalled offers are held stable
        pc_ctr = 32'h1000;
        for (int c = 0; c < 900; c++) begin
            if (!(if_valid && !m_push)) begin
                r = $urandom;
                if_valid = ($urandom_range(0, 3) != 0);
                if_instr = {r[31:7], ops[$urandom_range(0, 9)]};
                if_pc    = pc_ctr;
                pc_ctr   = pc_ctr + 32'd4;
            end
            if (c < 450) dq_ready = ($urandom_range(0, 2) == 0);
            else         dq_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            step();
        end
        if_valid = 1'b0; flush = 1'b0; dq_ready = 1'b1;
        repeat (DEPTH + 2) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
